// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Optional performance counters are built only when BPU_PERF_EN is defined.
module bpu_btb #(
    parameter int PC_W    = 64,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              pre_jump,
    output logic [PC_W-1:0]   pre_branch,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic [1:0]        upd_jumptype,
    input  logic              upd_mispredict,
    input  logic              flush,
    output logic [PERF_W-1:0] perf_total,
    output logic [PERF_W-1:0] perf_correct
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK = ~(CNT_MAX >> 1);

    logic [ENTRIES-1:0]            valid_all;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_all;
    logic [ENTRIES-1:0][PC_W-1:0]  target_all;
    logic [ENTRIES-1:0][CNT_W-1:0] cnt_all;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_cond;
    logic             upd_wr;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_next;
    logic [PC_W-1:0]  target_next;

    // Only the index/tag slices of the PCs are consumed.
    logic pc_unused;
    assign pc_unused = ^{lk_pc, upd_pc};

    assign lk_idx = lk_pc[IDX_W+1:2];
    assign lk_tag = lk_pc[TAG_W+IDX_W+1:IDX_W+2];
    assign lk_hit = valid_all[lk_idx] && (tag_all[lk_idx] == lk_tag);

    assign pre_jump   = lk_hit & cnt_all[lk_idx][CNT_W-1];
    assign pre_branch = pre_jump ? target_all[lk_idx] : '0;

    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[TAG_W+IDX_W+1:IDX_W+2];
    assign upd_hit  = valid_all[upd_idx] && (tag_all[upd_idx] == upd_tag);
    assign upd_cond = upd_valid && (upd_jumptype != 2'b00);
    assign cnt_cur  = cnt_all[upd_idx];

    always_comb begin
        upd_wr      = 1'b0;
        cnt_next    = cnt_cur;
        target_next = target_all[upd_idx];
        if (upd_cond && !flush) begin
            if (upd_hit) begin
                upd_wr = 1'b1;
                if (upd_jumptype == 2'b01) begin
                    if (upd_taken) begin
                        target_next = upd_target;
                        if (cnt_cur != CNT_MAX)
                            cnt_next = cnt_cur + CNT_W'(1);
                    end else if (cnt_cur != '0) begin
                        cnt_next = cnt_cur - CNT_W'(1);
                    end
                end else begin
                    cnt_next    = CNT_MAX;
                    target_next = upd_target;
                end
            end else if (upd_taken) begin
                // Allocation overwrites whatever lives at this index.
                upd_wr      = 1'b1;
                target_next = upd_target;
                cnt_next    = (upd_jumptype == 2'b01) ? CNT_WEAK : CNT_MAX;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [PC_W-1:0]  target_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    cnt_reg    <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (upd_wr && (upd_idx == IDX_W'(gi))) begin
                    valid_reg  <= 1'b1;
                    tag_reg    <= upd_tag;
                    target_reg <= target_next;
                    cnt_reg    <= cnt_next;
                end
            end

            assign valid_all[gi]  = valid_reg;
            assign tag_all[gi]    = tag_reg;
            assign target_all[gi] = target_reg;
            assign cnt_all[gi]    = cnt_reg;
        end
    endgenerate

`ifdef BPU_PERF_EN
    logic [PERF_W-1:0] perf_total_reg;
    logic [PERF_W-1:0] perf_correct_reg;
    logic              count_en;

    assign count_en = upd_cond && !flush;

    // Both counters saturate; flush leaves them alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_total_reg   <= '0;
            perf_correct_reg <= '0;
        end else if (count_en) begin
            if (perf_total_reg != {PERF_W{1'b1}})
                perf_total_reg <= perf_total_reg + PERF_W'(1);
            if (!upd_mispredict && (perf_correct_reg != {PERF_W{1'b1}}))
                perf_correct_reg <= perf_correct_reg + PERF_W'(1);
        end
    end

    assign perf_total   = perf_total_reg;
    assign perf_correct = perf_correct_reg;
`else
    logic perf_unused;
    assign perf_unused  = upd_mispredict;
    assign perf_total   = '0;
    assign perf_correct = '0;
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// Directed self-checking bench for bpu_btb: table of update/lookup vectors plus
// hand-written sequences for same-cycle, flush, async reset and perf corners.
module tb_bpu_btb;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] lk_pc;
    logic        pre_jump;
    logic [63:0] pre_branch;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic [1:0]  upd_jumptype;
    logic        upd_mispredict;
    logic        flush;
    logic [31:0] perf_total;
    logic [31:0] perf_correct;

    logic        pre_jump_s;
    logic [63:0] pre_branch_s;
    logic [2:0]  perf_total_s;
    logic [2:0]  perf_correct_s;

    int checks = 0;
    int errors = 0;
    int model_total = 0;
    int model_correct = 0;

    always #5 clock = ~clock;

    bpu_btb u_dut (
        .clock(clock), .reset(reset), .lk_pc(lk_pc),
        .pre_jump(pre_jump), .pre_branch(pre_branch),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_jumptype(upd_jumptype),
        .upd_mispredict(upd_mispredict), .flush(flush),
        .perf_total(perf_total), .perf_correct(perf_correct)
    );

    bpu_btb #(.PERF_W(3)) u_small (
        .clock(clock), .reset(reset), .lk_pc(lk_pc),
        .pre_jump(pre_jump_s), .pre_branch(pre_branch_s),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_jumptype(upd_jumptype),
        .upd_mispredict(upd_mispredict), .flush(flush),
        .perf_total(perf_total_s), .perf_correct(perf_correct_s)
    );

    typedef struct {
        logic        uv;
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
        logic [1:0]  jt;
        logic        mis;
        logic [63:0] lk;
        logic        exp_j;
        logic [63:0] exp_b;
    } vec_t;

    vec_t vecs [21];

    task automatic chk_lk(input string name, input logic [63:0] pc,
                          input logic exp_j, input logic [63:0] exp_b);
        lk_pc = pc;
        #1;
        checks++;
        if (pre_jump !== exp_j || pre_branch !== exp_b) begin
            errors++;
            $display("FAIL %s: got jump=%0b br=%h, expected jump=%0b br=%h",
                     name, pre_jump, pre_branch, exp_j, exp_b);
        end else
            $display("ok   %s: lk=%h jump=%0b br=%h", name, pc, pre_jump, pre_branch);
    endtask

    task automatic chk_perf(input string name);
        logic [31:0] et, ec;
        logic [2:0]  st, sc;
`ifdef BPU_PERF_EN
        et = 32'(model_total);
        ec = 32'(model_correct);
        st = (model_total > 7) ? 3'd7 : 3'(model_total);
        sc = (model_correct > 7) ? 3'd7 : 3'(model_correct);
`else
        et = '0; ec = '0; st = '0; sc = '0;
`endif
        checks++;
        if (perf_total !== et || perf_correct !== ec ||
            perf_total_s !== st || perf_correct_s !== sc) begin
            errors++;
            $display("FAIL %s: got total=%0d correct=%0d small=%0d/%0d, expected %0d/%0d small=%0d/%0d",
                     name, perf_total, perf_correct, perf_total_s, perf_correct_s, et, ec, st, sc);
        end else
            $display("ok   %s: total=%0d correct=%0d small=%0d/%0d",
                     name, perf_total, perf_correct, perf_total_s, perf_correct_s);
    endtask

    // Drive one update cycle; called at posedge+1, returns at posedge+1.
    task automatic upd(input logic uv, input logic [63:0] pc, input logic taken,
                       input logic [63:0] target, input logic [1:0] jt,
                       input logic mis, input logic fl);
        upd_valid = uv; upd_pc = pc; upd_taken = taken; upd_target = target;
        upd_jumptype = jt; upd_mispredict = mis; flush = fl;
        @(posedge clock);
        if (uv && jt != 2'b00 && !fl) begin
            model_total++;
            if (!mis) model_correct++;
        end
        #1;
        upd_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1, 64'h80000010, 1, 64'h80000100, 2'b01, 0, 64'h80000010, 1, 64'h80000100};
        vecs[1]  = '{1, 64'h80000010, 0, 64'h0,        2'b01, 1, 64'h80000010, 0, 64'h0};
        vecs[2]  = '{1, 64'h80000010, 0, 64'h0,        2'b01, 0, 64'h80000010, 0, 64'h0};
        vecs[3]  = '{1, 64'h80000010, 0, 64'h0,        2'b01, 0, 64'h80000010, 0, 64'h0};
        vecs[4]  = '{1, 64'h80000010, 1, 64'h80000100, 2'b01, 1, 64'h80000010, 0, 64'h0};
        vecs[5]  = '{1, 64'h80000010, 1, 64'h80000100, 2'b01, 1, 64'h80000010, 1, 64'h80000100};
        vecs[6]  = '{1, 64'h80000010, 1, 64'h80000100, 2'b01, 0, 64'h80000010, 1, 64'h80000100};
        vecs[7]  = '{1, 64'h80000010, 1, 64'h80000100, 2'b01, 0, 64'h80000010, 1, 64'h80000100};
        vecs[8]  = '{1, 64'h80000010, 0, 64'h0,        2'b01, 1, 64'h80000010, 1, 64'h80000100};
        vecs[9]  = '{1, 64'h80000010, 0, 64'h0,        2'b01, 1, 64'h80000010, 0, 64'h0};
        vecs[10] = '{1, 64'h80000010, 1, 64'h80000100, 2'b01, 1, 64'h80000010, 1, 64'h80000100};
        vecs[11] = '{1, 64'h80000010, 1, 64'h80000999, 2'b00, 0, 64'h80000010, 1, 64'h80000100};
        vecs[12] = '{0, 64'h80000010, 0, 64'h0,        2'b00, 0, 64'h80000410, 0, 64'h0};
        vecs[13] = '{1, 64'h80000410, 1, 64'h80002000, 2'b11, 1, 64'h80000410, 1, 64'h80002000};
        vecs[14] = '{0, 64'h80000010, 0, 64'h0,        2'b00, 0, 64'h80000010, 0, 64'h0};
        vecs[15] = '{1, 64'h80000410, 0, 64'h80003000, 2'b01, 1, 64'h80000410, 1, 64'h80002000};
        vecs[16] = '{1, 64'h80000810, 0, 64'h80004000, 2'b01, 0, 64'h80000410, 1, 64'h80002000};
        vecs[17] = '{1, 64'h80000020, 1, 64'h80000040, 2'b01, 1, 64'h80000020, 1, 64'h80000040};
        vecs[18] = '{1, 64'h80000020, 0, 64'h0,        2'b01, 1, 64'h80000020, 0, 64'h0};
        vecs[19] = '{1, 64'h80000020, 1, 64'h80000080, 2'b10, 0, 64'h80000020, 1, 64'h80000080};
        vecs[20] = '{1, 64'h80000020, 0, 64'h80000500, 2'b01, 0, 64'h80000020, 1, 64'h80000080};

        reset = 1'b1; lk_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_jumptype = 2'b00; upd_mispredict = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        chk_lk("reset_lookup", 64'h80000010, 1'b0, 64'h0);
        chk_perf("reset_perf");

        for (int i = 0; i < 21; i++) begin
            upd(vecs[i].uv, vecs[i].pc, vecs[i].taken, vecs[i].target,
                vecs[i].jt, vecs[i].mis, 1'b0);
            chk_lk($sformatf("vec%0d", i), vecs[i].lk, vecs[i].exp_j, vecs[i].exp_b);
        end
        chk_perf("table_perf");

        // Same-cycle lookup sees the pre-edge entry (cnt 10 -> 01).
        lk_pc = 64'h80000020;
        upd_valid = 1'b1; upd_pc = 64'h80000020; upd_taken = 1'b0;
        upd_target = '0; upd_jumptype = 2'b01; upd_mispredict = 1'b1;
        chk_lk("same_cycle_old", 64'h80000020, 1'b1, 64'h80000080);
        @(posedge clock);
        model_total++;
        #1 upd_valid = 1'b0;
        chk_lk("same_cycle_new", 64'h80000020, 1'b0, 64'h0);

        // Flush with a concurrent update: lookup in that cycle uses old state.
        lk_pc = 64'h80000410;
        upd_valid = 1'b1; upd_pc = 64'h80000040; upd_taken = 1'b1;
        upd_target = 64'h80000123; upd_jumptype = 2'b10; upd_mispredict = 1'b0; flush = 1'b1;
        chk_lk("flush_cycle_old", 64'h80000410, 1'b1, 64'h80002000);
        @(posedge clock);
        #1 upd_valid = 1'b0; flush = 1'b0;
        chk_lk("flush_invalid", 64'h80000410, 1'b0, 64'h0);
        chk_lk("flush_upd_lost", 64'h80000040, 1'b0, 64'h0);
        chk_perf("flush_perf");

        // Reallocate after flush, then async reset mid-update.
        upd(1'b1, 64'h80000010, 1'b1, 64'h80000100, 2'b10, 1'b0, 1'b0);
        chk_lk("realloc_jal", 64'h80000010, 1'b1, 64'h80000100);
        upd_valid = 1'b1; upd_pc = 64'h80000020; upd_taken = 1'b1;
        upd_target = 64'h80000700; upd_jumptype = 2'b11; upd_mispredict = 1'b0;
        #2 reset = 1'b1;
        model_total = 0; model_correct = 0;
        chk_lk("async_reset", 64'h80000010, 1'b0, 64'h0);
        chk_perf("async_reset_perf");
        @(posedge clock);
        #1 upd_valid = 1'b0; reset = 1'b0;
        chk_lk("reset_upd_dropped", 64'h80000020, 1'b0, 64'h0);

        // Perf: 5 counted (2 mispredicted) plus one ignored, then 4 more.
        upd(1'b1, 64'h80000010, 1'b1, 64'h80000100, 2'b01, 1'b0, 1'b0);
        upd(1'b1, 64'h80000010, 1'b0, 64'h0,        2'b01, 1'b1, 1'b0);
        upd(1'b1, 64'h80000020, 1'b1, 64'h80000200, 2'b10, 1'b0, 1'b0);
        upd(1'b1, 64'h80000030, 1'b1, 64'h80000300, 2'b00, 1'b1, 1'b0);
        upd(1'b1, 64'h80000030, 1'b1, 64'h80000300, 2'b11, 1'b1, 1'b0);
        upd(1'b1, 64'h80000020, 1'b1, 64'h80000200, 2'b10, 1'b0, 1'b0);
        chk_perf("perf_5_3");
        chk_lk("perf_lookup_jalr", 64'h80000030, 1'b1, 64'h80000300);
        for (int i = 0; i < 4; i++)
            upd(1'b1, 64'h80000020, 1'b1, 64'h80000200, 2'b10, 1'b0, 1'b0);
        chk_perf("perf_9_sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpu_btb.md
Name: bpu_btb

Overview:
Parametrised branch prediction unit: a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. It generalises the single-bit predict/check path of the decode stage.
- IF side: combinational lookup by fetch PC returns pre_jump / pre_branch. The result travels with the instruction to decode.
- ID side: decode returns the resolved outcome (taken, target, jump type, mispredict) on a one-cycle update port. All table state changes on the clock edge.

Parameters:
PC_W, 64, PC and target width.
ENTRIES, 16, BTB depth; power of two, >=2; IDX_W = log2(ENTRIES).
TAG_W, 8, tag bits stored per entry; PC_W >= TAG_W+IDX_W+2.
CNT_W, 2, direction counter width (>=1).
PERF_W, 32, width of performance counters.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
lk_pc  in  PC_W  fetch PC to look up.
pre_jump  out  1  predicted taken (combinational from lk_pc).
pre_branch  out  PC_W  predicted target; 0 when pre_jump=0.
upd_valid  in  1  decode has a resolved control-transfer instruction this cycle.
upd_pc  in  PC_W  PC of that instruction.
upd_taken  in  1  actual direction (decode mux_pc).
upd_target  in  PC_W  actual target (decode branch).
upd_jumptype  in  2  00 none, 01 B-type, 10 JAL, 11 JALR taken.
upd_mispredict  in  1  decode error_pre for this instruction.
flush  in  1  synchronous invalidate of all entries (fence.i).
perf_total  out  PERF_W  resolved control transfers counted.
perf_correct  out  PERF_W  correctly predicted control transfers.

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[TAG_W+IDX_W+1:IDX_W+2]. Entry = {valid, tag, target, cnt}.
- Lookup (combinational): hit = valid & tag match.
  - pre_jump = hit & cnt[CNT_W-1].
  - pre_branch = pre_jump ? target : 0.
  - Lookup sees pre-edge state; no bypass of a same-cycle update.
- Update, at the clock edge when upd_valid=1 and upd_jumptype!=00:
  - Hit, jumptype 01: cnt saturating +1 if taken, else saturating -1. target <= upd_target if taken.
  - Hit, jumptype 10/11: cnt <= all ones; target <= upd_target.
  - Miss & taken: allocate (overwrite the index). valid=1, tag, target. cnt = 1 followed by CNT_W-1 zeros (weak taken), or all ones for jumptype 10/11.
  - Miss & not taken: no change.
  - upd_valid=1 with jumptype=00: ignored entirely, including the perf counters.
- Saturation: cnt never wraps, neither at all-ones nor at zero.
- flush=1: all valid bits cleared at the edge. A same-cycle update is dropped. Lookup in the flush cycle still uses old state.
- Reset (async, any time, mid-update included): all valid=0, cnt=0, target=0, tag=0, perf counters=0. Hence pre_jump=0 and pre_branch=0 immediately.
- Aliasing: different tag at the same index is a miss. A taken update replaces the resident entry.
- Latency: an update is visible to lookup on the cycle after the edge that writes it.

Optional Feature:
BPU_PERF_EN defined:
- perf_total increments on every counted update (upd_valid & jumptype!=00, not flushed).
- perf_correct increments when such an update also has upd_mispredict=0.
- Both counters saturate at all ones and do not wrap.
- Reset clears both; flush does not.

BPU_PERF_EN undefined:
- No counter registers are built.
- perf_total and perf_correct are tied to 0.

Test Plan:
1. Reset, lk_pc=0x80000010 -> pre_jump=0, pre_branch=0. Update pc=0x80000010, taken=1, target=0x80000100, jumptype=01 -> next cycle lookup gives pre_jump=1, pre_branch=0x80000100 (cnt=10).
2. Continuing from 1: two not-taken updates on 0x80000010 -> cnt 10->01 (pre_jump=0) ->00. A third not-taken update keeps cnt=00.
3. Saturation: from cnt=10, two taken updates -> cnt=11; a further taken update keeps cnt=11. Then one not-taken update -> cnt=10, pre_jump still 1.
4. Alias: entry at 0x80000010 valid; lookup 0x80000410 (same index 4, tag 0x10 vs 0x00) -> miss, pre_jump=0. JALR update at 0x80000410 with target 0x80002000 -> entry replaced, cnt=11. Lookup 0x80000010 now misses.
5. Simultaneous events: update and lookup on the same PC in one cycle -> lookup shows old value. Flush asserted together with an update -> all entries invalid next cycle and the update is lost. Assert reset mid-stream -> outputs 0 without waiting for a clock edge.
6. With BPU_PERF_EN: 5 B/J updates including 2 with upd_mispredict=1, plus 1 update with jumptype=00 -> perf_total=5, perf_correct=3. With PERF_W=3 and 9 counted updates -> perf_total=7. Without the macro -> both outputs 0.
